// File: rtl/brat_checkpoint_ctrl.sv
// Branch checkpoint controller: one RAT snapshot per in-flight branch,
// with dependence masks for squash and CDB-maintained ready bits.
module brat_checkpoint_ctrl #(
   parameter int BRAT_DEPTH = 4,
   parameter int ARCH_REGS  = 32,
   parameter int PHYS_REGS  = 64,
   parameter int PT         = $clog2(PHYS_REGS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      alloc_req,
   input  logic [ARCH_REGS*PT-1:0]   rat_value_in,
   input  logic [ARCH_REGS-1:0]      rat_ready_in,
   output logic                      alloc_gnt,
   output logic [BRAT_DEPTH-1:0]     alloc_tag,
   output logic                      full,
   output logic [BRAT_DEPTH-1:0]     active_mask,
   input  logic                      resolve_valid,
   input  logic [BRAT_DEPTH-1:0]     resolve_tag,
   input  logic                      resolve_mispredict,
   input  logic                      cdb_valid,
   input  logic [PT-1:0]             cdb_tag,
   output logic                      checkpoint_write,
   output logic [ARCH_REGS*PT-1:0]   checkpoint_rat_value_out,
   output logic [ARCH_REGS-1:0]      checkpoint_rat_ready_out,
   output logic [BRAT_DEPTH-1:0]     squash_mask,
   output logic [BRAT_DEPTH-1:0]     clear_mask
);

   logic [BRAT_DEPTH-1:0]   valid;
   logic [BRAT_DEPTH-1:0]   dep [BRAT_DEPTH];
   logic [ARCH_REGS*PT-1:0] snap_value [BRAT_DEPTH];
   logic [ARCH_REGS-1:0]    snap_ready [BRAT_DEPTH];

   logic                    res_hit;
   logic                    mis;
   logic                    correct;
   logic [BRAT_DEPTH-1:0]   free_oh;
   logic                    found;
   logic [BRAT_DEPTH-1:0]   kill;
   logic [BRAT_DEPTH-1:0]   valid_n;
   logic [BRAT_DEPTH-1:0]   young;
   logic [ARCH_REGS*PT-1:0] rest_val;
   logic [ARCH_REGS-1:0]    rest_rdy;

   function automatic logic [ARCH_REGS-1:0] cdb_hits(
      input logic [ARCH_REGS*PT-1:0] v,
      input logic                    cv,
      input logic [PT-1:0]           ct
   );
      logic [ARCH_REGS-1:0] h;
      h = '0;
      for (int r = 0; r < ARCH_REGS; r++)
         h[r] = cv && (v[r*PT +: PT] == ct);
      return h;
   endfunction

   assign res_hit     = resolve_valid & |(resolve_tag & valid);
   assign mis         = res_hit & resolve_mispredict;
   assign correct     = res_hit & ~resolve_mispredict;
   assign full        = &valid;
   assign active_mask = valid;
   assign alloc_gnt   = alloc_req & ~full & ~mis;
   assign alloc_tag   = alloc_gnt ? free_oh : '0;
   assign clear_mask  = correct ? resolve_tag : '0;
   assign squash_mask = mis ? (resolve_tag | young) : '0;

   assign checkpoint_write         = mis;
   assign checkpoint_rat_value_out = mis ? rest_val : '0;
   assign checkpoint_rat_ready_out = mis ? rest_rdy : '0;

   always_comb begin
      free_oh = '0;
      found   = 1'b0;
      for (int i = 0; i < BRAT_DEPTH; i++) begin
         if (!valid[i] && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // One-hot resolve tag lets the restore mux be a plain OR of selected slots.
   always_comb begin
      rest_val = '0;
      rest_rdy = '0;
      young    = '0;
      for (int s = 0; s < BRAT_DEPTH; s++) begin
         young[s] = valid[s] & |(dep[s] & resolve_tag);
         if (resolve_tag[s]) begin
            rest_val = rest_val | snap_value[s];
            rest_rdy = rest_rdy | snap_ready[s]
                     | cdb_hits(snap_value[s], cdb_valid, cdb_tag);
         end
      end
   end

   always_comb begin
      kill    = squash_mask | clear_mask;
      valid_n = (valid & ~kill) | alloc_tag;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         for (int j = 0; j < BRAT_DEPTH; j++)
            dep[j] <= '0;
      end else begin
         valid <= valid_n;
         for (int j = 0; j < BRAT_DEPTH; j++) begin
            if (alloc_tag[j])
               dep[j] <= valid & ~clear_mask;
            else
               dep[j] <= dep[j] & ~kill;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int j = 0; j < BRAT_DEPTH; j++) begin
         if (alloc_tag[j]) begin
            snap_value[j] <= rat_value_in;
            snap_ready[j] <= rat_ready_in
                           | cdb_hits(rat_value_in, cdb_valid, cdb_tag);
         end else if (valid[j]) begin
            snap_ready[j] <= snap_ready[j]
                           | cdb_hits(snap_value[j], cdb_valid, cdb_tag);
         end
      end
   end

   a_resolve_onehot: assert property (
      @(posedge clock) disable iff (reset)
      resolve_valid |-> $onehot(resolve_tag));

endmodule

// File: tb/tb_brat_checkpoint_ctrl.sv
// Directed bench for brat_checkpoint_ctrl: allocation, resolve,
// mispredict restore/squash and CDB ready tracking.
module tb_brat_checkpoint_ctrl;

   localparam int D  = 4;
   localparam int A  = 32;
   localparam int P  = 64;
   localparam int PT = 6;

   logic            clock = 1'b0;
   logic            reset;
   logic            alloc_req;
   logic [A*PT-1:0] rat_value_in;
   logic [A-1:0]    rat_ready_in;
   logic            alloc_gnt;
   logic [D-1:0]    alloc_tag;
   logic            full;
   logic [D-1:0]    active_mask;
   logic            resolve_valid;
   logic [D-1:0]    resolve_tag;
   logic            resolve_mispredict;
   logic            cdb_valid;
   logic [PT-1:0]   cdb_tag;
   logic            checkpoint_write;
   logic [A*PT-1:0] checkpoint_rat_value_out;
   logic [A-1:0]    checkpoint_rat_ready_out;
   logic [D-1:0]    squash_mask;
   logic [D-1:0]    clear_mask;

   int vectors = 0;
   int miscompares = 0;

   brat_checkpoint_ctrl #(
      .BRAT_DEPTH(D), .ARCH_REGS(A), .PHYS_REGS(P)
   ) dut (
      .clock(clock), .reset(reset),
      .alloc_req(alloc_req),
      .rat_value_in(rat_value_in), .rat_ready_in(rat_ready_in),
      .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .full(full), .active_mask(active_mask),
      .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
      .resolve_mispredict(resolve_mispredict),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .checkpoint_write(checkpoint_write),
      .checkpoint_rat_value_out(checkpoint_rat_value_out),
      .checkpoint_rat_ready_out(checkpoint_rat_ready_out),
      .squash_mask(squash_mask), .clear_mask(clear_mask)
   );

   always #5 clock = ~clock;

   function automatic logic [A*PT-1:0] mk_map(input int base);
      logic [A*PT-1:0] m;
      m = '0;
      for (int r = 0; r < A; r++)
         m[r*PT +: PT] = PT'((base + r) % P);
      return m;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alloc_req          = 1'b0;
      rat_value_in       = '0;
      rat_ready_in       = '0;
      resolve_valid      = 1'b0;
      resolve_tag        = '0;
      resolve_mispredict = 1'b0;
      cdb_valid          = 1'b0;
      cdb_tag            = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic alloc_one(input int base, input logic [A-1:0] rdy);
      idle();
      alloc_req    = 1'b1;
      rat_value_in = mk_map(base);
      rat_ready_in = rdy;
      tick();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_full: got %b want 0", full);
      end
      vectors++;
      if (active_mask !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_active: got %b want 0000", active_mask);
      end
      vectors++;
      if (alloc_gnt !== 1'b0 || checkpoint_write !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outs: gnt %b wr %b want 0 0",
                  alloc_gnt, checkpoint_write);
      end
   endtask

   task automatic test_fill();
      logic [D-1:0] exp;
      do_reset();
      for (int i = 0; i < D; i++) begin
         idle();
         alloc_req    = 1'b1;
         rat_value_in = mk_map(i);
         #1;
         exp = D'(1) << i;
         vectors++;
         if (alloc_gnt !== 1'b1 || alloc_tag !== exp) begin
            miscompares++;
            $display("FAIL fill_tag%0d: gnt %b tag %b want 1 %b",
                     i, alloc_gnt, alloc_tag, exp);
         end
         tick();
      end
      idle();
      vectors++;
      if (full !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_full: got %b want 1", full);
      end
      alloc_req = 1'b1;
      #1;
      vectors++;
      if (alloc_gnt !== 1'b0 || alloc_tag !== 4'b0000) begin
         miscompares++;
         $display("FAIL fill_fifth: gnt %b tag %b want 0 0000",
                  alloc_gnt, alloc_tag);
      end
      vectors++;
      if (active_mask !== 4'b1111) begin
         miscompares++;
         $display("FAIL fill_active: got %b want 1111", active_mask);
      end
      tick();
      idle();
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_one(10, 32'h1111_0000);
      alloc_one(20, 32'hA5A5_0F0F);
      alloc_one(30, 32'h0000_FFFF);
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0010;
      resolve_mispredict = 1'b1;
      #1;
      vectors++;
      if (checkpoint_write !== 1'b1) begin
         miscompares++;
         $display("FAIL mis_write: got %b want 1", checkpoint_write);
      end
      vectors++;
      if (checkpoint_rat_value_out !== mk_map(20)) begin
         miscompares++;
         $display("FAIL mis_value: got %h want %h",
                  checkpoint_rat_value_out, mk_map(20));
      end
      vectors++;
      if (checkpoint_rat_ready_out !== 32'hA5A5_0F0F) begin
         miscompares++;
         $display("FAIL mis_ready: got %h want a5a50f0f",
                  checkpoint_rat_ready_out);
      end
      vectors++;
      if (squash_mask !== 4'b0110 || clear_mask !== 4'b0000) begin
         miscompares++;
         $display("FAIL mis_squash: sq %b clr %b want 0110 0000",
                  squash_mask, clear_mask);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (active_mask !== 4'b0001) begin
         miscompares++;
         $display("FAIL mis_after: got %b want 0001", active_mask);
      end
   endtask

   task automatic test_correct();
      do_reset();
      alloc_one(1, '0);
      alloc_one(2, '0);
      resolve_valid = 1'b1;
      resolve_tag   = 4'b0001;
      #1;
      vectors++;
      if (clear_mask !== 4'b0001 || squash_mask !== 4'b0000
          || checkpoint_write !== 1'b0
          || checkpoint_rat_value_out !== '0) begin
         miscompares++;
         $display("FAIL cor_clear: clr %b sq %b wr %b want 0001 0000 0",
                  clear_mask, squash_mask, checkpoint_write);
      end
      tick();
      idle();
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0010;
      resolve_mispredict = 1'b1;
      #1;
      vectors++;
      if (squash_mask !== 4'b0010) begin
         miscompares++;
         $display("FAIL cor_squash: got %b want 0010", squash_mask);
      end
      tick();
      // Slot 2 loses its dependence on slot 1 when slot 1 resolves correctly.
      do_reset();
      alloc_one(1, '0);
      alloc_one(2, '0);
      alloc_one(3, '0);
      resolve_valid = 1'b1;
      resolve_tag   = 4'b0010;
      tick();
      alloc_one(4, '0);
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0010;
      resolve_mispredict = 1'b1;
      #1;
      vectors++;
      if (squash_mask !== 4'b0010) begin
         miscompares++;
         $display("FAIL cor_depclr: got %b want 0010", squash_mask);
      end
      tick();
      idle();
   endtask

   task automatic test_cdb();
      logic [A*PT-1:0] m;
      m = mk_map(0);
      m[5*PT +: PT] = 6'd40;
      for (int pass = 0; pass < 3; pass++) begin
         do_reset();
         alloc_req    = 1'b1;
         rat_value_in = m;
         if (pass == 2) begin
            cdb_valid = 1'b1;
            cdb_tag   = 6'd40;
         end
         tick();
         idle();
         if (pass == 0) begin
            cdb_valid = 1'b1;
            cdb_tag   = 6'd40;
            tick();
            idle();
         end
         resolve_valid      = 1'b1;
         resolve_tag        = 4'b0001;
         resolve_mispredict = 1'b1;
         if (pass == 1) begin
            cdb_valid = 1'b1;
            cdb_tag   = 6'd40;
         end
         #1;
         vectors++;
         if (checkpoint_rat_ready_out !== 32'h0000_0020
             || checkpoint_rat_value_out !== m) begin
            miscompares++;
            $display("FAIL cdb_ready%0d: got %h want 00000020",
                     pass, checkpoint_rat_ready_out);
         end
         tick();
         idle();
      end
   endtask

   task automatic test_full_resolve();
      do_reset();
      for (int i = 0; i < D; i++)
         alloc_one(i, '0);
      alloc_req     = 1'b1;
      resolve_valid = 1'b1;
      resolve_tag   = 4'b0100;
      #1;
      vectors++;
      if (alloc_gnt !== 1'b0 || clear_mask !== 4'b0100) begin
         miscompares++;
         $display("FAIL fr_same: gnt %b clr %b want 0 0100",
                  alloc_gnt, clear_mask);
      end
      tick();
      idle();
      alloc_req = 1'b1;
      #1;
      vectors++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 4'b0100) begin
         miscompares++;
         $display("FAIL fr_next: gnt %b tag %b want 1 0100",
                  alloc_gnt, alloc_tag);
      end
      tick();
      idle();
      vectors++;
      if (full !== 1'b1) begin
         miscompares++;
         $display("FAIL fr_full: got %b want 1", full);
      end
   endtask

   task automatic test_alloc_mispredict();
      do_reset();
      alloc_one(7, '0);
      alloc_req          = 1'b1;
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0001;
      resolve_mispredict = 1'b1;
      #1;
      vectors++;
      if (alloc_gnt !== 1'b0 || squash_mask !== 4'b0001) begin
         miscompares++;
         $display("FAIL am_same: gnt %b sq %b want 0 0001",
                  alloc_gnt, squash_mask);
      end
      tick();
      idle();
      vectors++;
      if (active_mask !== 4'b0000) begin
         miscompares++;
         $display("FAIL am_after: got %b want 0000", active_mask);
      end
   endtask

   task automatic test_invalid_resolve();
      do_reset();
      alloc_one(3, '0);
      resolve_valid      = 1'b1;
      resolve_tag        = 4'b0100;
      resolve_mispredict = 1'b1;
      #1;
      vectors++;
      if (checkpoint_write !== 1'b0 || squash_mask !== 4'b0000
          || checkpoint_rat_ready_out !== '0) begin
         miscompares++;
         $display("FAIL inv_mis: wr %b sq %b want 0 0000",
                  checkpoint_write, squash_mask);
      end
      tick();
      resolve_mispredict = 1'b0;
      #1;
      vectors++;
      if (clear_mask !== 4'b0000 || active_mask !== 4'b0001) begin
         miscompares++;
         $display("FAIL inv_cor: clr %b act %b want 0000 0001",
                  clear_mask, active_mask);
      end
      tick();
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_fill();
      test_mispredict();
      test_correct();
      test_cdb();
      test_full_resolve();
      test_alloc_mispredict();
      test_invalid_resolve();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/brat_checkpoint_ctrl.md
Name: brat_checkpoint_ctrl

Overview:
Branch checkpoint controller for the rename stage.
- Allocates a RAT snapshot slot per dispatched branch and tracks each slot's dependence on older unresolved branches.
- On a correct resolve, frees that slot.
- On a mispredict, drives the RAT restore port and reports every squashed slot.
- Keeps the ready bits of stored snapshots current from the CDB.

Parameters:
BRAT_DEPTH, 4, number of checkpoint slots (max in-flight branches)
ARCH_REGS, 32, architectural registers per snapshot
PHYS_REGS, 64, physical registers; PT = $clog2(PHYS_REGS) is the tag width

Ports:
clock  in  1  system clock
reset  in  1  reset
alloc_req  in  1  branch dispatching this cycle, needs a checkpoint
rat_value_in  in  ARCH_REGS*PT  RAT next-state map (snapshot source)
rat_ready_in  in  ARCH_REGS  RAT next-state ready bits
alloc_gnt  out  1  checkpoint allocated this cycle
alloc_tag  out  BRAT_DEPTH  one-hot slot granted (0 if no grant)
full  out  1  all slots valid; dispatch of branches must stall
active_mask  out  BRAT_DEPTH  currently valid slots (branch mask for dispatching instrs)
resolve_valid  in  1  a branch resolves this cycle
resolve_tag  in  BRAT_DEPTH  one-hot slot of the resolving branch
resolve_mispredict  in  1  1 = mispredicted, 0 = correct
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  PT  completing physical tag
checkpoint_write  out  1  RAT restore enable
checkpoint_rat_value_out  out  ARCH_REGS*PT  restored map
checkpoint_rat_ready_out  out  ARCH_REGS  restored ready bits
squash_mask  out  BRAT_DEPTH  slots killed this cycle (to RS/ROB/LSQ)
clear_mask  out  BRAT_DEPTH  slots correctly resolved this cycle

Behaviour:
Reset is synchronous, active-high, on reset; clock is clock.

Per-slot state: valid, snap_value[ARCH_REGS], snap_ready[ARCH_REGS], dep[BRAT_DEPTH].

Reset:
- All valid=0, dep=0.
- Outputs evaluate to 0: full=0, active_mask=0, alloc_gnt=0.

Outputs:
- full = &valid (registered state only).
- active_mask = valid.
- All other outputs are combinational from the current state and this cycle's inputs.
- State updates on the next clock edge.

Allocation:
- alloc_gnt = alloc_req & ~full & ~mis, where mis = resolve_valid & resolve_mispredict & |(resolve_tag & valid).
- Granted slot is the lowest-index invalid slot.
- At the edge the slot takes:
  - valid=1
  - snap_value=rat_value_in
  - snap_ready = rat_ready_in OR the CDB match this cycle
  - dep = valid & ~(correct-resolved slot)
- A slot freed this cycle is not reusable until the next cycle.

Correct resolve (resolve_valid, !resolve_mispredict, resolved slot valid):
- clear_mask = resolve_tag.
- At the edge: that slot's valid=0, and its bit is cleared from every slot's dep.

Mispredict (mis=1, slot s):
- checkpoint_write=1.
- checkpoint_rat_value_out = snap_value[s].
- checkpoint_rat_ready_out = snap_ready[s] OR (cdb_valid & value==cdb_tag), bitwise forwarded.
- squash_mask = resolve_tag | {slots j valid with dep[j][s]=1}.
- At the edge all squash_mask slots become invalid, and their bits are cleared from every remaining slot's dep.
- A same-cycle alloc is suppressed (the new branch is younger than s).

CDB:
- When cdb_valid, every valid slot sets snap_ready[r]=1 for each r with snap_value[r]==cdb_tag.
- Never clears ready bits.

Ignored inputs:
- Resolve on an invalid slot produces no outputs and no state change.
- resolve_tag that is not one-hot is illegal (assertion).

When no restore occurs, checkpoint_rat_* outputs are 0.

Reset mid-operation discards all slots; no restore is issued.

Test Plan:
1. Reset, then 4 alloc_req cycles, then a 5th: alloc_tag 0001, 0010, 0100, 1000; full=1 after the 4th edge; 5th alloc_gnt=0, active_mask=1111.
2. Slots 0,1,2 allocated in order; mispredict slot 1 -> checkpoint_write=1, value = snapshot taken at slot-1 alloc, squash_mask=0110; next cycle active_mask=0001.
3. Slots 0,1 valid; correct resolve slot 0 -> clear_mask=0001; next cycle slot 1 dep=0; a later mispredict of slot 1 gives squash_mask=0010 only.
4. Snapshot slot 0 holds r5->P40, not ready; cdb_tag=40 one cycle later; mispredict slot 0 next cycle -> checkpoint_rat_ready_out[5]=1. Repeat with CDB and mispredict in the same cycle -> also 1 (forwarding).
5. Full with alloc_req and correct resolve of slot 2 in the same cycle -> alloc_gnt=0; next cycle alloc_req -> alloc_tag=0100.
6. alloc_req with a mispredict of slot 0 in the same cycle -> alloc_gnt=0, no slot becomes valid.
